// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks: MAC state
// encoding, elaboration-time sizing helpers and the accumulator width rule.
package nn_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        SAT   = 2'd2,
        OUT   = 2'd3
    } mac_state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // The accumulator must hold N_INPUTS full-scale products plus the bias without wrapping.
    function automatic bit acc_width_ok(input int data_width, input int n_inputs,
                                        input int acc_width);
        return (acc_width >= 2 * data_width + clog2(n_inputs) + 1);
    endfunction

endpackage

// File: rtl/sat_to_addr.sv
// Converts a signed accumulator into an offset-binary LUT address:
// arithmetic shift, clamp to the signed address range, then invert the MSB.
module sat_to_addr #(
    parameter int ACC_WIDTH  = 24,
    parameter int SHIFT      = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam logic signed [ACC_WIDTH-1:0] S_MAX =
        ACC_WIDTH'((64'sd1 <<< (ADDR_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] S_MIN = ~S_MAX;

    logic signed [ACC_WIDTH-1:0] s;

    always_comb begin
        s = $signed(acc) >>> SHIFT;
        if (s > S_MAX) begin
            addr = '1;
        end else if (s < S_MIN) begin
            addr = '0;
        end else begin
            addr = {~s[ADDR_WIDTH-1], s[ADDR_WIDTH-2:0]};
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// One-neuron pipelined multiply-accumulate with bias, producing an
// activation-LUT address per N_INPUTS accepted beats under valid/ready.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_INPUTS   = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int SHIFT      = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_x,
    input  logic [DATA_WIDTH-1:0]   in_w,
    input  logic [2*DATA_WIDTH-1:0] in_bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_WIDTH-1:0]   addr_out
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int CNT_W = (N_INPUTS > 1) ? clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

    if (N_INPUTS < 1 || !acc_width_ok(DATA_WIDTH, N_INPUTS, ACC_WIDTH)) begin : g_bad_params
        $error("neuron_mac: ACC_WIDTH too small for DATA_WIDTH/N_INPUTS");
    end

    mac_state_e                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [PW-1:0]        prod_q, prod_d;
    logic                        prod_vld_q, prod_vld_d;
    logic                        out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;

    logic                        accept;
    logic [ADDR_WIDTH-1:0]       addr_sat;
    logic signed [PW-1:0]        x_ext, w_ext;
    logic signed [ACC_WIDTH-1:0] prod_ext, bias_ext;

    assign accept   = (state_q == ACCUM) && in_valid;
    assign x_ext    = {{DATA_WIDTH{in_x[DATA_WIDTH-1]}}, in_x};
    assign w_ext    = {{DATA_WIDTH{in_w[DATA_WIDTH-1]}}, in_w};
    assign prod_ext = {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};
    assign bias_ext = {{(ACC_WIDTH-PW){in_bias[PW-1]}}, in_bias};

    sat_to_addr #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_sat_to_addr (
        .acc (acc_q),
        .addr(addr_sat)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        prod_vld_d  = 1'b0;
        out_valid_d = out_valid_q;
        addr_d      = addr_q;

        case (state_q)
            ACCUM: begin
                if (prod_vld_q) begin
                    acc_d = acc_q + prod_ext;
                end
                if (accept) begin
                    prod_d     = x_ext * w_ext;
                    prod_vld_d = 1'b1;
                    // Beat 0 never has a product in flight, so the bias load cannot lose one.
                    if (cnt_q == '0) begin
                        acc_d = bias_ext;
                    end
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (prod_vld_q) begin
                    acc_d = acc_q + prod_ext;
                end
                state_d = SAT;
            end
            SAT: begin
                addr_d      = addr_sat;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            out_valid_q <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            out_valid_q <= out_valid_d;
            addr_q      <= addr_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = out_valid_q;
    assign addr_out  = addr_q;

endmodule
